uart_baudgen_frac: RTL and testbench

Programmable fractional baud-rate generator for the UART. It produces a single-cycle receive oversampling strobe and a transmit bit strobe from the system clock. The divisor is loadable at run time with a fractional part, so 115200 baud and other rates are hit with bounded error from any system clock. The block feeds the UART receiver (rx_tick) and transmitter (tx_tick). tx_tick is derived from rx_tick, so the two stay phase-coherent.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_frac_div.sv | 91 +++++++++
 rtl/uart_baudgen_frac.sv | 68 ++++++
 tb/tb_uart_baudgen_frac.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART baud-generator constants, divisor record type and clamp helper.
package uart_pkg;
  localparam int UART_INT_W    = 16;
  localparam int UART_FRAC_W   = 8;
  localparam int MIN_DIV       = 2;
  localparam int UART_DEF_INT  = 13;   // 25 MHz / (115200 * 16) = 13.563
  localparam int UART_DEF_FRAC = 144;  // 0.563 * 256

  typedef struct packed {
    logic [UART_INT_W-1:0]  int_part;
    logic [UART_FRAC_W-1:0] frac_part;
  } uart_div_t;

  function automatic int clamp_div(input int v);
    return (v < MIN_DIV) ? MIN_DIV : v;
  endfunction
endpackage

// File: rtl/uart_frac_div.sv
// Fractional period divider producing rx_tick; shadow divisor applied on a tick boundary.
// Registered strobe, no backpressure; accumulator present only with UART_BAUDGEN_FRAC_EN.
module uart_frac_div
  import uart_pkg::*;
#(
  parameter int INT_W    = UART_INT_W,
  parameter int FRAC_W   = UART_FRAC_W,
  parameter int DEF_INT  = UART_DEF_INT,
  parameter int DEF_FRAC = UART_DEF_FRAC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              div_wr,
  input  logic [INT_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  output logic              div_busy,
  output logic              tick_pre,
  output logic              rx_tick
);
  typedef struct packed {
    logic [INT_W-1:0]  int_part;
    logic [FRAC_W-1:0] frac_part;
  } div_cfg_t;

  localparam logic [INT_W-1:0]  RST_INT  = INT_W'(clamp_div(DEF_INT));
  localparam logic [FRAC_W-1:0] RST_FRAC = FRAC_W'(DEF_FRAC);
  localparam div_cfg_t          RST_DIV  = '{int_part: RST_INT, frac_part: RST_FRAC};

  div_cfg_t          cur_q, shd_q;
  logic [INT_W-1:0]  cnt_q, reload, wr_int;
  logic              pend_q, applied_q, rx_tick_q;
  logic              carry;

  assign wr_int   = (div_int < INT_W'(MIN_DIV)) ? INT_W'(MIN_DIV) : div_int;
  assign tick_pre = en && (cnt_q == '0);

`ifdef UART_BAUDGEN_FRAC_EN
  logic [FRAC_W-1:0] acc_q;
  logic [FRAC_W:0]   acc_sum;

  assign acc_sum = {1'b0, acc_q} + {1'b0, cur_q.frac_part};
  assign carry   = acc_sum[FRAC_W];

  always_ff @(posedge clk) begin
    if (!rst_n)
      acc_q <= '0;
    else if (tick_pre)
      acc_q <= pend_q ? '0 : acc_sum[FRAC_W-1:0];
  end
`else
  logic unused_frac;
  assign unused_frac = ^cur_q.frac_part;
  assign carry       = 1'b0;
`endif

  // A freshly applied divisor starts from a cleared accumulator, so its first period is exactly int.
  assign reload = pend_q ? (shd_q.int_part - 1'b1)
                         : (carry ? cur_q.int_part : (cur_q.int_part - 1'b1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_q     <= RST_DIV;
      shd_q     <= RST_DIV;
      cnt_q     <= RST_INT - 1'b1;
      pend_q    <= 1'b0;
      applied_q <= 1'b0;
      rx_tick_q <= 1'b0;
    end else begin
      rx_tick_q <= tick_pre;
      applied_q <= tick_pre && pend_q;
      if (tick_pre) begin
        cnt_q <= reload;
        if (pend_q)
          cur_q <= shd_q;
      end else if (en) begin
        cnt_q <= cnt_q - 1'b1;
      end
      // A write on the applying edge keeps the newer shadow pending for the next tick.
      if (div_wr) begin
        shd_q  <= '{int_part: wr_int, frac_part: div_frac};
        pend_q <= 1'b1;
      end else if (tick_pre) begin
        pend_q <= 1'b0;
      end
    end
  end

  assign rx_tick  = rx_tick_q;
  assign div_busy = pend_q | applied_q;
endmodule

// File: rtl/uart_baudgen_frac.sv
// UART baud generator: rx oversampling strobe plus phase-coherent tx bit strobe, one clock domain.
// Strobes registered, no backpressure; fractional divide built only with UART_BAUDGEN_FRAC_EN.
module uart_baudgen_frac
  import uart_pkg::*;
#(
  parameter int INT_W      = UART_INT_W,
  parameter int FRAC_W     = UART_FRAC_W,
  parameter int OVERSAMPLE = 16,
  parameter int DEF_INT    = UART_DEF_INT,
  parameter int DEF_FRAC   = UART_DEF_FRAC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              div_wr,
  input  logic [INT_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  output logic              div_busy,
  input  logic              tx_sync,
  output logic              rx_tick,
  output logic              tx_tick
);
  localparam int              PH_W    = $clog2(OVERSAMPLE);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVERSAMPLE - 1);

  logic            tick_pre;
  logic [PH_W-1:0] phase_q;
  logic            tx_tick_q;

  uart_frac_div #(
    .INT_W    (INT_W),
    .FRAC_W   (FRAC_W),
    .DEF_INT  (DEF_INT),
    .DEF_FRAC (DEF_FRAC)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .div_wr   (div_wr),
    .div_int  (div_int),
    .div_frac (div_frac),
    .div_busy (div_busy),
    .tick_pre (tick_pre),
    .rx_tick  (rx_tick)
  );

  // tx_sync takes priority over a wrapping tick so the frame restarts at phase 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q   <= '0;
      tx_tick_q <= 1'b0;
    end else begin
      tx_tick_q <= 1'b0;
      if (tx_sync) begin
        phase_q <= '0;
      end else if (tick_pre) begin
        if (phase_q == PH_LAST) begin
          phase_q   <= '0;
          tx_tick_q <= 1'b1;
        end else begin
          phase_q <= phase_q + 1'b1;
        end
      end
    end
  end

  assign tx_tick = tx_tick_q;
endmodule

// File: tb/tb_uart_baudgen_frac.sv
// Directed bench for uart_baudgen_frac; expectations follow UART_BAUDGEN_FRAC_EN.
module tb_uart_baudgen_frac;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic        div_wr = 1'b0;
  logic [15:0] div_int = '0;
  logic [7:0]  div_frac = '0;
  logic        div_busy;
  logic        tx_sync = 1'b0;
  logic        rx_tick;
  logic        tx_tick;

`ifdef UART_BAUDGEN_FRAC_EN
  localparam int EXP_HI    = 14;
  localparam int EXP_P23   = 14;
  localparam int EXP_SUM   = 3472;
  localparam int EXP_TXGAP = 217;  // 16*13 + carries at ticks 16..31 (17 - 8)
`else
  localparam int EXP_HI    = 13;
  localparam int EXP_P23   = 13;
  localparam int EXP_SUM   = 3328;
  localparam int EXP_TXGAP = 208;
`endif

  uart_baudgen_frac dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .div_wr   (div_wr),
    .div_int  (div_int),
    .div_frac (div_frac),
    .div_busy (div_busy),
    .tx_sync  (tx_sync),
    .rx_tick  (rx_tick),
    .tx_tick  (tx_tick)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_err = 0;
  int rx_n = 0, tx_n = 0, rx_last = 0, rx_wide = 0, tx_wide = 0, tx_orphan = 0;
  int rx_min_gap = 100000, tx_c1 = 0, tx_c2 = 0, tx_rx_first = 0;
  logic rx_prev = 1'b0, tx_prev = 1'b0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge and log strobe activity.
  task automatic step();
    @(negedge clk);
    if (rx_tick) begin
      if (rx_prev) rx_wide++;
      else if (rx_n > 0 && (cyc - rx_last) < rx_min_gap) rx_min_gap = cyc - rx_last;
      rx_n++;
      rx_last = cyc;
    end
    if (tx_tick) begin
      if (tx_prev) tx_wide++;
      if (!rx_tick) tx_orphan++;
      tx_n++;
      if (tx_n == 1) begin tx_c1 = cyc; tx_rx_first = rx_n; end
      if (tx_n == 2) tx_c2 = cyc;
    end
    rx_prev = rx_tick;
    tx_prev = tx_tick;
  endtask

  task automatic wait_rx(input string tag, output int per);
    int start;
    int n0;
    start = rx_last;
    n0    = rx_n;
    per   = -1;
    for (int k = 0; k < 400; k++) begin
      step();
      if (rx_n != n0) begin
        per = rx_last - start;
        return;
      end
    end
    chk({tag, "_timeout"}, 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, per, p12, p23, t1, bad, n0, t0, ns, nt;
    repeat (3) step();
    chk("rst_rx_tick", rx_tick, 0);
    chk("rst_tx_tick", tx_tick, 0);
    chk("rst_busy", div_busy, 0);

    rst_n = 1'b1;
    c0 = cyc;
    wait_rx("first", per);
    chk("first_rx_latency", rx_last - c0, 13);

    // 256 periods from tick 1 to tick 257
    t1 = rx_last; bad = 0; p12 = 0; p23 = 0;
    for (int k = 0; k < 256; k++) begin
      wait_rx("run", per);
      if (k == 0) p12 = per;
      if (k == 1) p23 = per;
      if (per != 13 && per != EXP_HI) bad++;
    end
    chk("p_tick1_2", p12, 13);
    chk("p_tick2_3", p23, EXP_P23);
    chk("period_out_of_range", bad, 0);
    chk("sum_256_periods", rx_last - t1, EXP_SUM);
    chk("tx_first_at_rx", tx_rx_first, 16);
    chk("tx_count_257rx", tx_n, 16);
    chk("tx_gap_clocks", tx_c2 - tx_c1, EXP_TXGAP);

    // mid-period load of int=4
    repeat (5) step();
    div_int = 16'd4; div_frac = 8'd0; div_wr = 1'b1;
    step();
    div_wr = 1'b0;
    chk("busy_rise", div_busy, 1);
    wait_rx("old", per);
    chk("old_period_kept", per, 13);
    chk("busy_at_apply_tick", div_busy, 1);
    step();
    chk("busy_fall", div_busy, 0);
    wait_rx("n4a", per); chk("new_period_4a", per, 4);
    wait_rx("n4b", per); chk("new_period_4b", per, 4);

    // two writes before the tick: last wins
    div_int = 16'd5; div_wr = 1'b1;
    step();
    div_int = 16'd7;
    step();
    div_wr = 1'b0;
    wait_rx("p4c", per); chk("period_before_7", per, 4);
    wait_rx("p7", per);  chk("last_write_wins", per, 7);

    // write in the rx_tick cycle: held to next tick; int=1 clamps to 2
    div_int = 16'd1; div_wr = 1'b1;
    step();
    div_wr = 1'b0;
    wait_rx("h7", per); chk("held_to_next_tick", per, 7);
    wait_rx("c2a", per); chk("clamp_period_a", per, 2);
    wait_rx("c2b", per); chk("clamp_period_b", per, 2);
    div_int = 16'd6; div_wr = 1'b1;
    step();
    div_wr = 1'b0;
    wait_rx("c2c", per); chk("clamp_period_c", per, 2);
    wait_rx("p6", per);  chk("period_6", per, 6);

    // tx_sync coinciding with a tx-producing tick
    for (int k = 0; k < 17 && (rx_n % 16) != 15; k++) wait_rx("align", per);
    repeat (5) step();
    tx_sync = 1'b1;
    step();
    tx_sync = 1'b0;
    chk("sync_rx_tick", rx_tick, 1);
    chk("sync_tx_suppressed", tx_tick, 0);
    n0 = rx_n; t0 = tx_n;
    for (int k = 0; k < 20 && tx_n == t0; k++) wait_rx("sync", per);
    chk("sync_next_tx_rx", rx_n - n0, 16);

    // en low 50 cycles mid-period, with a write captured while disabled
    repeat (2) step();
    en = 1'b0; ns = rx_n; nt = tx_n;
    for (int i = 0; i < 50; i++) begin
      step();
      if (i == 10) begin div_int = 16'd3; div_wr = 1'b1; end
      if (i == 11) div_wr = 1'b0;
    end
    chk("off_rx_ticks", rx_n - ns, 0);
    chk("off_tx_ticks", tx_n - nt, 0);
    chk("busy_while_off", div_busy, 1);
    en = 1'b1;
    wait_rx("resume", per); chk("resume_period", per, 56);
    step();
    chk("busy_after_resume", div_busy, 0);
    wait_rx("p3", per); chk("period_after_resume", per, 3);

    // reset aborts a pending load
    div_int = 16'd9; div_wr = 1'b1;
    step();
    div_wr = 1'b0;
    chk("busy_before_rst", div_busy, 1);
    rst_n = 1'b0;
    step();
    chk("rst_mid_busy", div_busy, 0);
    chk("rst_mid_rx", rx_tick, 0);
    chk("rst_mid_tx", tx_tick, 0);
    step();
    rst_n = 1'b1;
    c0 = cyc;
    wait_rx("rfirst", per);
    chk("rst_first_latency", rx_last - c0, 13);
    wait_rx("rp2", per);
    chk("rst_second_period", per, 13);
    chk("rst_busy_stays_low", div_busy, 0);

    chk("rx_strobe_wide", rx_wide, 0);
    chk("tx_strobe_wide", tx_wide, 0);
    chk("tx_without_rx", tx_orphan, 0);
    chk("rx_min_gap", rx_min_gap, 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
